// File: rtl/uart_pkg.sv
// uart_pkg: shared types for the buffered UART transmitter
package uart_pkg;
    typedef logic [15:0] word;
    typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_t;
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} tx_state_t;
endpackage

// File: rtl/uart_tx_buffered_fifo.sv
// sync_fifo: registered FIFO with occupancy count; a write into a full FIFO is taken only alongside a read
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;
    logic do_wr, do_rd;
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign full    = level_q == LW'(DEPTH);
    assign empty   = level_q == '0;
    assign level   = level_q;
    assign rd_data = mem_q[rd_ptr_q];
    // storage needs no reset: pointers and count alone define what is valid
    always_ff @(posedge clk_i) if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    // pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_q + LW'(do_wr) - LW'(do_rd);
        end
    end
endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-fed UART serialiser with per-frame latched parity/stop/prescaler config
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    localparam int LEVEL_W   = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  word                prescaler,
    input  parity_t            parity_mode,
    input  logic               two_stop,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic               wr_en,
    input  logic               clr_ovf,
    output logic               tx,
    output logic               busy,
    output logic               full,
    output logic [LEVEL_W-1:0] level,
    output logic               overflow
);
    tx_state_t state_q, state_d;
    word cnt_q, cnt_d, pre_q, pre_d;
    logic [3:0] bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d, head;
    parity_t mode_q, mode_d;
    logic two_q, two_d, stop_q, stop_d, par_q, par_d, tx_q, tx_d, ovf_q, ovf_d;
    logic empty, load, bit_end;
    sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i(clk_i), .reset_i(reset_i), .wr_en(wr_en), .wr_data(wr_data), .rd_en(load),
        .rd_data(head), .full(full), .empty(empty), .level(level)
    );
    assign bit_end  = cnt_q == '0;
    assign tx       = tx_q;
    assign busy     = state_q != ST_IDLE || !empty;
    assign overflow = ovf_q;
    // frame sequencer: advances one bit per expired bit period, reloading from the FIFO without a gap
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        pre_d   = pre_q;
        mode_d  = mode_q;
        two_d   = two_q;
        stop_d  = stop_q;
        tx_d    = tx_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: load = !empty;
            ST_START: if (bit_end) begin
                state_d = ST_DATA;
                tx_d    = shift_q[0];
                shift_d = shift_q >> 1;
                bit_d   = '0;
            end
            ST_DATA: if (bit_end) begin
                if (bit_q == 4'(DATA_W - 1)) begin
                    state_d = mode_q == PAR_NONE ? ST_STOP : ST_PARITY;
                    tx_d    = mode_q == PAR_NONE ? 1'b1 : mode_q == PAR_ODD ? ~par_q : par_q;
                    stop_d  = 1'b0;
                end else begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 4'd1;
                end
            end
            ST_PARITY: if (bit_end) begin
                state_d = ST_STOP;
                tx_d    = 1'b1;
                stop_d  = 1'b0;
            end
            ST_STOP: if (bit_end) begin
                if (two_q && !stop_q) stop_d = 1'b1;
                else begin
                    state_d = ST_IDLE;
                    load    = !empty;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_q != ST_IDLE) cnt_d = bit_end ? pre_q : cnt_q - word'(1);
        if (load) begin
            state_d = ST_START;
            tx_d    = 1'b0;
            shift_d = head;
            par_d   = ^head;
            pre_d   = prescaler;
            mode_d  = parity_mode;
            two_d   = two_stop;
            cnt_d   = prescaler;
        end
        ovf_d = (wr_en && full && !load) ? 1'b1 : clr_ovf ? 1'b0 : ovf_q;
    end
    // state registers; reset aborts any frame and returns the line to idle-high
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            pre_q   <= '0;
            mode_q  <= PAR_NONE;
            two_q   <= 1'b0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            pre_q   <= pre_d;
            mode_q  <= mode_d;
            two_q   <= two_d;
            stop_q  <= stop_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: randomized scenario bench with a frame-level serial reference model
module tb_uart_tx_buffered;
    import uart_pkg::*;
    localparam int DW = 8;
    localparam int DEPTH = 16;
    logic clk = 1'b0, reset_i = 1'b1, two_stop = 1'b0, wr_en = 1'b0, clr_ovf = 1'b0;
    word prescaler = '0;
    parity_t parity_mode = PAR_NONE;
    logic [DW-1:0] wr_data = '0;
    logic tx, busy, full, overflow;
    logic [$clog2(DEPTH):0] level;
    int n_checks = 0, n_err = 0;

    always #5 clk = ~clk;

    uart_tx_buffered #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk), .reset_i(reset_i), .prescaler(prescaler), .parity_mode(parity_mode),
        .two_stop(two_stop), .wr_data(wr_data), .wr_en(wr_en), .clr_ovf(clr_ovf),
        .tx(tx), .busy(busy), .full(full), .level(level), .overflow(overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
    endtask

    // expected line = start, data LSB first, optional parity, stop(s); each symbol held p+1 cycles
    task automatic expect_frame(input logic [DW-1:0] d, input int p, input parity_t m, input logic two, input string tag);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(d[i]);
        if (m != PAR_NONE) bits.push_back(m == PAR_EVEN ? ^d : ~^d);
        bits.push_back(1'b1);
        if (two) bits.push_back(1'b1);
        foreach (bits[b]) begin
            for (int c = 0; c <= p; c++) begin
                n_checks++;
                if (tx !== bits[b] || busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL %s d=%h sym%0d cyc%0d tx=%b busy=%b expected tx=%b busy=1", tag, d, b, c, tx, busy, bits[b]);
                end
                tick();
            end
        end
    endtask

    task automatic send_one(input logic [DW-1:0] d, input int p, input parity_t m, input logic two, input string tag);
        prescaler = word'(p);
        parity_mode = m;
        two_stop = two;
        wr_data = d;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        tick();
        expect_frame(d, p, m, two, tag);
        n_checks++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            n_err++;
            $display("FAIL %s_after busy=%b tx=%b expected busy=0 tx=1", tag, busy, tx);
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
        n_checks++;
        if ({tx, busy, full, overflow} !== 4'b1000 || level !== '0) begin
            n_err++;
            $display("FAIL reset tx/busy/full/ovf=%b level=%0d expected 1000 level=0", {tx, busy, full, overflow}, level);
        end
    endtask

    task automatic test_single();
        prescaler = 16'd3;
        parity_mode = PAR_NONE;
        two_stop = 1'b0;
        wr_data = 8'h42;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        n_checks++;
        if (tx !== 1'b1 || busy !== 1'b1 || level !== 1) begin
            n_err++;
            $display("FAIL single_n1 tx=%b busy=%b level=%0d expected tx=1 busy=1 level=1", tx, busy, level);
        end
        tick();
        expect_frame(8'h42, 3, PAR_NONE, 1'b0, "single");
        n_checks++;
        if (busy !== 1'b0 || tx !== 1'b1 || level !== 0) begin
            n_err++;
            $display("FAIL single_end busy=%b tx=%b level=%0d expected 0 1 0", busy, tx, level);
        end
    endtask

    task automatic test_parity();
        send_one(8'h07, 1, PAR_EVEN, 1'b0, "par_even");
        send_one(8'h07, 1, PAR_ODD, 1'b1, "par_odd_2stop");
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] q[3];
        foreach (q[i]) q[i] = DW'($urandom);
        prescaler = '0;
        parity_mode = PAR_NONE;
        two_stop = 1'b0;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    wr_data = q[i];
                    wr_en = 1'b1;
                    tick();
                end
                wr_en = 1'b0;
            end
            begin
                tick();
                tick();
                for (int i = 0; i < 3; i++) expect_frame(q[i], 0, PAR_NONE, 1'b0, "b2b");
                n_checks++;
                if (busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL b2b_end busy=%b expected 0", busy);
                end
            end
        join
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            send_one(DW'($urandom), int'($urandom_range(0, 3)), parity_t'($urandom_range(0, 2)),
                     1'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_overflow();
        do_reset();
        prescaler = 16'hFFFF;
        parity_mode = PAR_NONE;
        two_stop = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            wr_data = DW'($urandom);
            wr_en = 1'b1;
            tick();
            if (i == DEPTH) begin
                n_checks++;
                if (full !== 1'b1 || overflow !== 1'b0 || level !== DEPTH) begin
                    n_err++;
                    $display("FAIL ovf_fill full=%b ovf=%b level=%0d expected 1 0 %0d", full, overflow, level, DEPTH);
                end
            end
        end
        wr_en = 1'b0;
        n_checks++;
        if (full !== 1'b1 || overflow !== 1'b1 || level !== DEPTH || tx !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_set full=%b ovf=%b level=%0d tx=%b expected 1 1 %0d 0", full, overflow, level, tx, DEPTH);
        end
        wr_en = 1'b1;
        clr_ovf = 1'b1;
        tick();
        wr_en = 1'b0;
        n_checks++;
        if (overflow !== 1'b1 || level !== DEPTH) begin
            n_err++;
            $display("FAIL ovf_set_wins ovf=%b level=%0d expected 1 %0d", overflow, level, DEPTH);
        end
        tick();
        clr_ovf = 1'b0;
        n_checks++;
        if (overflow !== 1'b0 || full !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_clear ovf=%b full=%b expected 0 1", overflow, full);
        end
        do_reset();
    endtask

    task automatic test_full_pop();
        logic [DW-1:0] q[DEPTH + 2];
        foreach (q[i]) q[i] = DW'($urandom);
        prescaler = 16'd1;
        parity_mode = PAR_NONE;
        two_stop = 1'b0;
        fork
            begin
                for (int i = 0; i < DEPTH + 1; i++) begin
                    wr_data = q[i];
                    wr_en = 1'b1;
                    tick();
                end
                wr_en = 1'b0;
                repeat (4) tick();
                n_checks++;
                if (full !== 1'b1 || level !== DEPTH) begin
                    n_err++;
                    $display("FAIL fullpop_pre full=%b level=%0d expected 1 %0d", full, level, DEPTH);
                end
                wr_data = q[DEPTH + 1];
                wr_en = 1'b1;
                tick();
                wr_en = 1'b0;
                n_checks++;
                if (full !== 1'b1 || level !== DEPTH || overflow !== 1'b0) begin
                    n_err++;
                    $display("FAIL fullpop_post full=%b level=%0d ovf=%b expected 1 %0d 0", full, level, overflow, DEPTH);
                end
            end
            begin
                tick();
                tick();
                for (int i = 0; i < DEPTH + 2; i++) expect_frame(q[i], 1, PAR_NONE, 1'b0, "fullpop");
                n_checks++;
                if (busy !== 1'b0 || level !== 0) begin
                    n_err++;
                    $display("FAIL fullpop_end busy=%b level=%0d expected 0 0", busy, level);
                end
            end
        join
    endtask

    task automatic test_reset_mid();
        prescaler = 16'd3;
        parity_mode = PAR_NONE;
        two_stop = 1'b0;
        wr_data = 8'h00;
        wr_en = 1'b1;
        tick();
        wr_data = 8'hFF;
        tick();
        wr_en = 1'b0;
        repeat (6) tick();
        n_checks++;
        if (tx !== 1'b0 || level !== 1) begin
            n_err++;
            $display("FAIL mid_data tx=%b level=%0d expected 0 1", tx, level);
        end
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        n_checks++;
        if (tx !== 1'b1 || level !== 0 || busy !== 1'b0 || full !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset tx=%b level=%0d busy=%b full=%b expected 1 0 0 0", tx, level, busy, full);
        end
        send_one(8'h5A, 3, PAR_ODD, 1'b0, "post_reset");
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_parity();
        test_back_to_back();
        test_random();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
